alu_mult_issue_arbiter: RTL and testbench
=========================================

// Module: alu_mult_issue_arbiter
// PURPOSE
//  Issue scheduler between NUM_OC operand-collector (OC) requesters and the shared
//  execute resources: the single-cycle ALU and the multi-cycle, non-pipelined MULT.
//  Grants one ALU op and one MULT op per cycle using independent round-robin pointers.
//  Tracks MULT occupancy and owns the single CDB write slot, selecting ALU or MULT.
//  Sits between the OC stage and the ALU/MULT units; its selects drive the OC->ALU/MULT muxes.
// PARAMETERS
//  NUM_OC        4  number of OC requesters (>=2)
//  MULT_LATENCY  4  MULT issue-to-CDB cycles (>=2)
//  SEL_W         2  clog2(NUM_OC)
// PORTS
//  clk               in   1       clock, rising edge
//  rst_n             in   1       asynchronous active-low reset
//  Req_OC_Arb        in   NUM_OC  OC[i] holds a ready instruction
//  IsMult_OC_Arb     in   NUM_OC  OC[i] instruction targets MULT (else ALU)
//  Grant_Arb_OC      out  NUM_OC  one-hot-or-zero per class; OC[i] accepted this cycle
//  Valid_Arb_ALU     out  1       ALU issues this cycle
//  Sel_Arb_ALU       out  SEL_W   OC index driving ALU
//  Valid_Arb_MULT    out  1       MULT issues this cycle
//  Sel_Arb_MULT      out  SEL_W   OC index driving MULT
//  MultBusy_Arb      out  1       MULT occupied, no MULT issue possible
//  CdbSel_Arb_CDB    out  2       CDB source: 00 none, 01 ALU, 10 MULT
// BEHAVIOUR
//  State: AluPtr, MultPtr (SEL_W each), MultCnt (0..MULT_LATENCY). All reset to 0.
//  Outputs are combinational from state and inputs; all forced 0 while rst_n=0.
//  Classes: ALU-req = Req & ~IsMult; MULT-req = Req & IsMult.
//  ALU RR: grant first ALU-req at index >= AluPtr (wrapping NUM_OC-1 -> 0).
//   On grant AluPtr <= granted+1 (mod NUM_OC); else unchanged.
//  MULT RR: same scheme with MultPtr and MULT-req.
//  MultWb = (MultCnt==1): MULT result occupies the CDB this cycle.
//  MultBusy_Arb = (MultCnt>1). MULT grant only when MultCnt<=1 (back-to-back
//   issue allowed in the writeback cycle).
//  ALU grant blocked while MultWb (ALU result would collide on CDB); ALU retried next cycle,
//   AluPtr not advanced.
//  MultCnt: MULT grant -> load MULT_LATENCY; else if nonzero -> decrement; else hold 0.
//  Latency: ALU result on CDB in grant cycle; MULT result on CDB exactly MULT_LATENCY
//   cycles after grant.
//  CdbSel_Arb_CDB = 10 if MultWb, else 01 if Valid_Arb_ALU, else 00. Never both.
//  Simultaneous ALU and MULT grants to different OCs allowed in one cycle.
//  Same OC never granted twice in a cycle (classes are disjoint by IsMult).
//  Grant_Arb_OC = ALU one-hot | MULT one-hot. Sel_* = 0 when corresponding Valid_* = 0.
//  OC must hold Req/IsMult stable until granted; arbiter does not latch requests.
//  Reset mid-MULT: MultCnt cleared, pending MULT writeback dropped (no CDB slot reserved).
//  Pointer wrap: grant at NUM_OC-1 sets pointer to 0.
// TESTING
//  Reset: rst_n=0, Req=1111 -> Grant=0000, CdbSel=00, MultBusy=0; release -> ALU grant OC0.
//  ALU RR: Req=1111, IsMult=0000, 5 cycles -> Grant 0001,0010,0100,1000,0001; CdbSel=01 each.
//  MULT latency: OC2 MULT req cycle 0 only -> Grant=0100 c0; MultBusy=1 c1-c3;
//   CdbSel=10 c4; MultBusy=0 c4.
//  Busy/back-to-back: OC1 MULT req held from c1 while OC2 MULT in flight (issued c0) ->
//   no grant c1-c3, Grant=0010 c4, next writeback c8.
//  CDB conflict: MULT issued c0, OC0 ALU req at c4 -> Grant=0000 c4 (CdbSel=10),
//   Grant=0001 c5 (CdbSel=01).
//  Dual issue: Req=0011, IsMult=0010 c0 -> Grant=0011, Sel_ALU=0, Sel_MULT=1; reset asserted
//   c2 -> no MULT writeback at c4.

Source files
------------

// File: rtl/alu_mult_issue_arbiter_if.sv
// Issue-side bundle between the operand collectors and the ALU/MULT arbiter.
// Requests flow in from the OCs; grants, selects and CDB source flow out.
interface alu_mult_issue_arbiter_if #(
    parameter int NUM_OC = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_OC-1:0] Req_OC_Arb;
    logic [NUM_OC-1:0] IsMult_OC_Arb;
    logic [NUM_OC-1:0] Grant_Arb_OC;
    logic              Valid_Arb_ALU;
    logic [SEL_W-1:0]  Sel_Arb_ALU;
    logic              Valid_Arb_MULT;
    logic [SEL_W-1:0]  Sel_Arb_MULT;
    logic              MultBusy_Arb;
    logic [1:0]        CdbSel_Arb_CDB;

    modport master (
        output Req_OC_Arb, IsMult_OC_Arb,
        input  Grant_Arb_OC, Valid_Arb_ALU, Sel_Arb_ALU,
        input  Valid_Arb_MULT, Sel_Arb_MULT, MultBusy_Arb, CdbSel_Arb_CDB
    );

    modport slave (
        input  Req_OC_Arb, IsMult_OC_Arb,
        output Grant_Arb_OC, Valid_Arb_ALU, Sel_Arb_ALU,
        output Valid_Arb_MULT, Sel_Arb_MULT, MultBusy_Arb, CdbSel_Arb_CDB
    );
endinterface

// File: rtl/alu_mult_issue_arbiter.sv
// Round-robin issue of one ALU op and one MULT op per cycle from the OCs.
// Tracks MULT occupancy and owns the single CDB write slot.
module alu_mult_issue_arbiter #(
    parameter int NUM_OC       = 4,
    parameter int MULT_LATENCY = 4,
    parameter int SEL_W        = 2
) (
    input logic               clk,
    input logic               rst_n,
    alu_mult_issue_arbiter_if.slave arb
);
    localparam int CNT_W = $clog2(MULT_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MULT_LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SEL_W-1:0]  alu_ptr;
    logic [SEL_W-1:0]  mult_ptr;
    logic [CNT_W-1:0]  mult_cnt;

    logic [NUM_OC-1:0] alu_req;
    logic [NUM_OC-1:0] mult_req;
    logic [SEL_W:0]    alu_pick;
    logic [SEL_W:0]    mult_pick;
    logic              mult_wb;
    logic              alu_go;
    logic              mult_go;

    // First set bit at or after ptr, wrapping; MSB of result is the hit flag.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [NUM_OC-1:0] r,
        input logic [SEL_W-1:0]  p
    );
        logic [2*NUM_OC-1:0] dbl;
        logic [SEL_W:0]      res;
        int                  idx;
        dbl = {r, r} >> p;
        res = '0;
        for (int i = NUM_OC - 1; i >= 0; i--) begin
            idx = int'(p) + i;
            if (idx >= NUM_OC) idx = idx - NUM_OC;
            if (dbl[i]) res = {1'b1, SEL_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_OC - 1)) ? '0 : s + SEL_W'(1);
    endfunction

    // Class split, RR selection, CDB ownership and gated outputs.
    always_comb begin
        alu_req  = arb.Req_OC_Arb & ~arb.IsMult_OC_Arb;
        mult_req = arb.Req_OC_Arb & arb.IsMult_OC_Arb;
        alu_pick  = rr_pick(alu_req, alu_ptr);
        mult_pick = rr_pick(mult_req, mult_ptr);
        mult_wb = (mult_cnt == ONE);
        alu_go  = rst_n & alu_pick[SEL_W] & ~mult_wb;
        mult_go = rst_n & mult_pick[SEL_W] & (mult_cnt <= ONE);

        arb.Grant_Arb_OC   = '0;
        arb.Valid_Arb_ALU  = alu_go;
        arb.Sel_Arb_ALU    = '0;
        arb.Valid_Arb_MULT = mult_go;
        arb.Sel_Arb_MULT   = '0;
        arb.MultBusy_Arb   = rst_n & (mult_cnt > ONE);
        arb.CdbSel_Arb_CDB = 2'b00;

        if (alu_go) begin
            arb.Sel_Arb_ALU  = alu_pick[SEL_W-1:0];
            arb.Grant_Arb_OC = arb.Grant_Arb_OC
                             | (NUM_OC'(1) << alu_pick[SEL_W-1:0]);
        end
        if (mult_go) begin
            arb.Sel_Arb_MULT = mult_pick[SEL_W-1:0];
            arb.Grant_Arb_OC = arb.Grant_Arb_OC
                             | (NUM_OC'(1) << mult_pick[SEL_W-1:0]);
        end
        if (rst_n && mult_wb)
            arb.CdbSel_Arb_CDB = 2'b10;
        else if (alu_go)
            arb.CdbSel_Arb_CDB = 2'b01;
    end

    // Advance RR pointers past each grant; count down MULT occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ptr  <= '0;
            mult_ptr <= '0;
            mult_cnt <= '0;
        end else begin
            if (alu_go)
                alu_ptr <= ptr_next(alu_pick[SEL_W-1:0]);
            if (mult_go) begin
                mult_ptr <= ptr_next(mult_pick[SEL_W-1:0]);
                mult_cnt <= LAT;
            end else if (mult_cnt != '0) begin
                mult_cnt <= mult_cnt - ONE;
            end
        end
    end
endmodule

// File: tb/tb_alu_mult_issue_arbiter.sv
// Bench for alu_mult_issue_arbiter: directed scenarios plus random traffic
// checked against a time-based model of grants and MULT writeback slots.
module tb_alu_mult_issue_arbiter;
    localparam int N  = 4;
    localparam int L  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    alu_mult_issue_arbiter_if #(.NUM_OC(N), .SEL_W(SW)) bus ();

    alu_mult_issue_arbiter #(
        .NUM_OC(N), .MULT_LATENCY(L), .SEL_W(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arb(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int now   = 0;
    int aptr  = 0;
    int mptr  = 0;
    int wb_at = -1;
    logic [N-1:0]  last_grant;
    logic [SW-1:0] last_sel_alu;
    logic [SW-1:0] last_sel_mult;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] m,
                       input int eg = -1, input int ec = -1,
                       input int eb = -1);
        int ga, gm, ecdb;
        bit wb, busy;
        logic [N-1:0] g;
        bus.Req_OC_Arb    = r;
        bus.IsMult_OC_Arb = m;
        #1;
        wb   = (wb_at == now);
        busy = (wb_at > now);
        ga = wb ? -1 : pick(r & ~m, aptr);
        gm = busy ? -1 : pick(r & m, mptr);
        g = '0;
        if (ga >= 0) g = g | (N'(1) << ga);
        if (gm >= 0) g = g | (N'(1) << gm);
        ecdb = wb ? 2 : ((ga >= 0) ? 1 : 0);
        chk("grant", 32'(bus.Grant_Arb_OC), 32'(g));
        chk("valid_alu", 32'(bus.Valid_Arb_ALU), 32'(ga >= 0));
        chk("sel_alu", 32'(bus.Sel_Arb_ALU), (ga >= 0) ? ga : 0);
        chk("valid_mult", 32'(bus.Valid_Arb_MULT), 32'(gm >= 0));
        chk("sel_mult", 32'(bus.Sel_Arb_MULT), (gm >= 0) ? gm : 0);
        chk("busy", 32'(bus.MultBusy_Arb), 32'(busy));
        chk("cdb", 32'(bus.CdbSel_Arb_CDB), ecdb);
        if (eg >= 0) chk("dir_grant", 32'(bus.Grant_Arb_OC), eg);
        if (ec >= 0) chk("dir_cdb", 32'(bus.CdbSel_Arb_CDB), ec);
        if (eb >= 0) chk("dir_busy", 32'(bus.MultBusy_Arb), eb);
        last_grant    = g;
        last_sel_alu  = bus.Sel_Arb_ALU;
        last_sel_mult = bus.Sel_Arb_MULT;
        @(posedge clk);
        if (ga >= 0) aptr = (ga + 1) % N;
        if (gm >= 0) begin
            mptr  = (gm + 1) % N;
            wb_at = now + L;
        end
        now++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Req_OC_Arb    = '1;
        bus.IsMult_OC_Arb = 4'b0101;
        #1;
        chk("rst_grant", 32'(bus.Grant_Arb_OC), 0);
        chk("rst_cdb", 32'(bus.CdbSel_Arb_CDB), 0);
        chk("rst_busy", 32'(bus.MultBusy_Arb), 0);
        chk("rst_valid", 32'({bus.Valid_Arb_ALU, bus.Valid_Arb_MULT}), 0);
        aptr  = 0;
        mptr  = 0;
        wb_at = -1;
        @(posedge clk);
        now++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] preq, pm;
        bus.Req_OC_Arb    = '0;
        bus.IsMult_OC_Arb = '0;

        do_reset();
        cyc(4'b1111, 4'b0000, 4'b0001, 1);
        cyc(4'b1111, 4'b0000, 4'b0010, 1);
        cyc(4'b1111, 4'b0000, 4'b0100, 1);
        cyc(4'b1111, 4'b0000, 4'b1000, 1);
        cyc(4'b1111, 4'b0000, 4'b0001, 1);

        cyc(4'b0100, 4'b0100, 4'b0100, 0, 0);
        repeat (3) cyc(4'b0000, 4'b0000, 0, 0, 1);
        cyc(4'b0000, 4'b0000, 0, 2, 0);

        cyc(4'b0100, 4'b0100, 4'b0100);
        repeat (3) cyc(4'b0010, 4'b0010, 0, 0, 1);
        cyc(4'b0010, 4'b0010, 4'b0010, 2, 0);
        repeat (3) cyc(4'b0000, 4'b0000, 0, 0, 1);
        cyc(4'b0000, 4'b0000, 0, 2, 0);

        cyc(4'b0100, 4'b0100, 4'b0100);
        repeat (3) cyc(4'b0000, 4'b0000);
        cyc(4'b0001, 4'b0000, 0, 2);
        cyc(4'b0001, 4'b0000, 4'b0001, 1);

        cyc(4'b0011, 4'b0010, 4'b0011, 1);
        chk("dual_sel_alu", 32'(last_sel_alu), 0);
        chk("dual_sel_mult", 32'(last_sel_mult), 1);
        cyc(4'b0000, 4'b0000);
        do_reset();
        cyc(4'b0000, 4'b0000, 0, 0, 0);
        cyc(4'b0000, 4'b0000, 0, 0, 0);

        preq = '0;
        pm   = '0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
                preq = '0;
                pm   = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (!preq[i] && $urandom_range(0, 1) == 1) begin
                    preq[i] = 1'b1;
                    pm[i]   = 1'($urandom_range(0, 1));
                end
            end
            cyc(preq, pm);
            preq = preq & ~last_grant;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
